booth_mult_n: RTL

Parametrised radix-2 Booth sequential multiplier, successor to the fixed 4-bit booth datapath/controller pair. It supports operand width N and a per-operation signed/unsigned mode, and adds busy status and a registered, held result. Controller FSM and datapath live in one module. It sits under the arithmetic top level and is driven by a start/done handshake.

---
 rtl/booth_mult_n.sv | 87 ++++++++
 1 files changed

// File: rtl/booth_mult_n.sv
// booth_mult_n: radix-2 Booth sequential multiplier, N-bit operands, signed/unsigned per operation.
module booth_mult_n #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sign_mode,
  input  logic [N-1:0]   data_M,
  input  logic [N-1:0]   data_Q,
  output logic [2*N-1:0] data_out,
  output logic           done,
  output logic           busy
);
  localparam int W = N + 1;
  localparam int CW = $clog2(N + 2);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, q_q, q_d, m_q, m_d, sum;
  logic [2*W-1:0] prod;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] data_out_q, data_out_d;
  logic qm1_q, qm1_d, done_q, done_d, busy_q, busy_d;
  // One extra bit lets zero-extended unsigned operands run through the signed Booth datapath.
  always_comb begin
    sum = (q_q[0] & ~qm1_q) ? a_q - m_q : (~q_q[0] & qm1_q) ? a_q + m_q : a_q;
    state_d = state_q;
    a_d = a_q;
    q_d = q_q;
    m_d = m_q;
    qm1_d = qm1_q;
    cnt_d = cnt_q;
    data_out_d = data_out_q;
    done_d = 1'b0;
    busy_d = busy_q;
    prod = '0;
    if (state_q == IDLE) begin
      if (start) begin
        m_d = sign_mode ? {data_M[N-1], data_M} : {1'b0, data_M};
        q_d = sign_mode ? {data_Q[N-1], data_Q} : {1'b0, data_Q};
        a_d = '0;
        qm1_d = 1'b0;
        cnt_d = CW'(W);
        busy_d = 1'b1;
        state_d = CALC;
      end
    end else begin
      a_d = {sum[W-1], sum[W-1:1]};
      q_d = {sum[0], q_q[W-1:1]};
      qm1_d = q_q[0];
      cnt_d = cnt_q - CW'(1);
      prod = {a_d, q_d};
      if (cnt_q == CW'(1)) begin
        data_out_d = prod[2*N-1:0];
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      q_q <= '0;
      m_q <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
      data_out_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      q_q <= q_d;
      m_q <= m_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_d;
      data_out_q <= data_out_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign data_out = data_out_q;
  assign done = done_q;
  assign busy = busy_q;
endmodule
